// File: rtl/mm_share_arbiter_if.sv
// mm_share_arbiter_if
// Bundles the requester, response and datapath signals of mm_share_arbiter.
//   master : arbiter view (accepts requests, drives responses and datapath strobes)
//   slave  : environment view (requesters, response consumer, multiplier datapath)
// Signals:
//   req0_valid/req0_ready/req0_ops : requester 0 operand handshake, ops {a1,b1,c1,d1,a2,b2,c2,d2}
//   req1_valid/req1_ready/req1_ops : requester 1, same layout
//   rsp_valid/rsp_ready            : response handshake
//   rsp_id/rsp_err/rsp_data        : requester tag, timeout flag, {r1,r2,r3,r4}
//   dp_load/dp_compute/dp_ops      : strobes and operands toward the multiplier
//   dp_valid/dp_res                : multiplier result strobe and value
interface mm_share_arbiter_if;
    logic         req0_valid;
    logic         req0_ready;
    logic [127:0] req0_ops;
    logic         req1_valid;
    logic         req1_ready;
    logic [127:0] req1_ops;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic         rsp_err;
    logic [127:0] rsp_data;
    logic         dp_load;
    logic         dp_compute;
    logic [127:0] dp_ops;
    logic         dp_valid;
    logic [127:0] dp_res;

    modport master (
        input  req0_valid, req0_ops, req1_valid, req1_ops, rsp_ready, dp_valid, dp_res,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, rsp_data,
               dp_load, dp_compute, dp_ops
    );

    modport slave (
        output req0_valid, req0_ops, req1_valid, req1_ops, rsp_ready, dp_valid, dp_res,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, rsp_data,
               dp_load, dp_compute, dp_ops
    );
endinterface

// File: rtl/mm_share_arbiter.sv
// mm_share_arbiter
// Shares one 2x2 signed matrix-multiply datapath between two requesters.
// Requests are granted round-robin in IDLE, the operands are presented to the
// datapath with a one-cycle load strobe followed by a one-cycle compute strobe,
// and the result (or a timeout error after TIMEOUT wait cycles) is returned
// tagged with the requester id over a valid/ready response port.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mm_share_arbiter_if.master (requests, response, datapath)
// Parameter:
//   TIMEOUT : maximum WAIT cycles for dp_valid before an error response (>=2)
module mm_share_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    mm_share_arbiter_if.master bus
);

    localparam int              CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    state_t         state_r;
    state_t         state_s;

    logic           last_r;        // requester granted most recently
    logic           id_r;          // requester of the operation in flight
    logic [CW-1:0]  cnt_r;         // WAIT cycle counter
    logic [127:0]   ops_r;
    logic [127:0]   rsp_data_r;
    logic           rsp_err_r;
    logic           rsp_valid_r;
    logic           dp_load_r;
    logic           dp_compute_r;

    logic           grant0_s;
    logic           grant1_s;
    logic           ready0_s;
    logic           ready1_s;
    logic           accept_s;
    logic           accept_id_s;
    logic           timeout_s;
    logic           rsp_hs_s;

    // Round-robin grant and the combinational ready/accept decode.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        // Requester 0 wins unless requester 1 also asks and 0 was served last.
        if (bus.req0_valid && (!bus.req1_valid || last_r)) begin
            grant0_s = 1'b1;
        end else if (bus.req1_valid) begin
            grant1_s = 1'b1;
        end else begin
            grant1_s = 1'b0;
        end
        // Ready is suppressed while rst is high so no accept can race the reset.
        ready0_s    = (state_r == ST_IDLE) && !rst && grant0_s && bus.req0_valid;
        ready1_s    = (state_r == ST_IDLE) && !rst && grant1_s && bus.req1_valid;
        accept_s    = (bus.req0_valid && ready0_s) || (bus.req1_valid && ready1_s);
        accept_id_s = ready1_s;
        timeout_s   = (cnt_r == CNT_LAST);
        rsp_hs_s    = rsp_valid_r && bus.rsp_ready;
    end

    // Next-state logic of the sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_LOAD;
                else          state_s = ST_IDLE;
            end
            ST_LOAD:    state_s = ST_COMPUTE;
            ST_COMPUTE: state_s = ST_WAIT;
            ST_WAIT: begin
                if (bus.dp_valid || timeout_s) state_s = ST_RESP;
                else                           state_s = ST_WAIT;
            end
            ST_RESP: begin
                if (rsp_hs_s) state_s = ST_IDLE;
                else          state_s = ST_RESP;
            end
            default:    state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_s;
    end

    // Registered outputs, operand/id capture, wait counter and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r       <= 1'b1;
            id_r         <= 1'b0;
            cnt_r        <= '0;
            ops_r        <= 128'd0;
            rsp_data_r   <= 128'd0;
            rsp_err_r    <= 1'b0;
            rsp_valid_r  <= 1'b0;
            dp_load_r    <= 1'b0;
            dp_compute_r <= 1'b0;
        end else begin
            // Strobes are decoded from the next state so they line up with the state.
            dp_load_r    <= (state_s == ST_LOAD);
            dp_compute_r <= (state_s == ST_COMPUTE);
            rsp_valid_r  <= (state_s == ST_RESP);

            if (accept_s) begin
                ops_r  <= accept_id_s ? bus.req1_ops : bus.req0_ops;
                id_r   <= accept_id_s;
                last_r <= accept_id_s;
            end else begin
                ops_r  <= ops_r;
                id_r   <= id_r;
                last_r <= last_r;
            end

            // Counter is zero on WAIT entry; it never runs past CNT_LAST because
            // WAIT is left in that cycle.
            if (state_r == ST_WAIT) cnt_r <= cnt_r + CW'(1);
            else                    cnt_r <= '0;

            // A result arriving on the final count still wins over the timeout.
            if (state_r == ST_WAIT && bus.dp_valid) begin
                rsp_data_r <= bus.dp_res;
                rsp_err_r  <= 1'b0;
            end else if (state_r == ST_WAIT && timeout_s) begin
                rsp_data_r <= 128'd0;
                rsp_err_r  <= 1'b1;
            end else begin
                rsp_data_r <= rsp_data_r;
                rsp_err_r  <= rsp_err_r;
            end
        end
    end

    assign bus.req0_ready = ready0_s;
    assign bus.req1_ready = ready1_s;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_id     = id_r;
    assign bus.rsp_err    = rsp_err_r;
    assign bus.rsp_data   = rsp_data_r;
    assign bus.dp_load    = dp_load_r;
    assign bus.dp_compute = dp_compute_r;
    assign bus.dp_ops     = ops_r;

endmodule

// File: tb/tb_mm_share_arbiter.sv
// Testbench for mm_share_arbiter: directed and randomized operations against a
// behavioural matrix-multiply datapath and a round-robin grant model.
module tb_mm_share_arbiter;

    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mm_share_arbiter_if bus();

    mm_share_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int           n_vec    = 0;
    int           n_err    = 0;
    int           dp_delay = 0;   // cycles after compute until valid; 0 = never
    int           dp_rem   = 0;
    logic [127:0] dp_prod;
    int           last_m   = 1;

    // 2x2 signed product [[a1,b1],[c1,d1]] x [[a2,b2],[c2,d2]]
    function automatic logic [127:0] matmul(input logic [127:0] ops);
        int a1, b1, c1, d1, a2, b2, c2, d2;
        logic [31:0] r1, r2, r3, r4;
        a1 = $signed(ops[127:112]); b1 = $signed(ops[111:96]);
        c1 = $signed(ops[95:80]);   d1 = $signed(ops[79:64]);
        a2 = $signed(ops[63:48]);   b2 = $signed(ops[47:32]);
        c2 = $signed(ops[31:16]);   d2 = $signed(ops[15:0]);
        r1 = 32'(a1 * a2 + b1 * c2);
        r2 = 32'(a1 * b2 + b1 * d2);
        r3 = 32'(c1 * a2 + d1 * c2);
        r4 = 32'(c1 * b2 + d1 * d2);
        return {r1, r2, r3, r4};
    endfunction

    function automatic logic [127:0] pack8(input int a1, b1, c1, d1, a2, b2, c2, d2);
        return {16'(a1), 16'(b1), 16'(c1), 16'(d1), 16'(a2), 16'(b2), 16'(c2), 16'(d2)};
    endfunction

    // Expected grant in IDLE: -1 none, else requester index.
    function automatic int mgrant(input bit v0, input bit v1, input int last);
        if (v0 && (!v1 || last == 1)) return 0;
        else if (v1)                  return 1;
        else                          return -1;
    endfunction

    // Behavioural datapath: product of the operands seen at load, valid dp_delay
    // cycles after compute, garbage on dp_res otherwise.
    always @(negedge clk) begin
        if (rst) begin
            dp_rem       = 0;
            bus.dp_valid = 1'b0;
        end else begin
            if (bus.dp_load) dp_prod = matmul(bus.dp_ops);
            if (bus.dp_compute) begin
                dp_rem       = dp_delay;
                bus.dp_valid = 1'b0;
            end else if (dp_rem > 0) begin
                dp_rem--;
                bus.dp_valid = (dp_rem == 0);
            end else begin
                bus.dp_valid = 1'b0;
            end
        end
        bus.dp_res = bus.dp_valid ? dp_prod : {$urandom, $urandom, $urandom, $urandom};
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctl"}, {bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id,
                            bus.rsp_err, bus.dp_load, bus.dp_compute}, 7'b0);
        chk({tag, "_rsp_data"}, bus.rsp_data, 128'd0);
        chk({tag, "_dp_ops"}, bus.dp_ops, 128'd0);
    endtask

    // Call just after a negedge with the requester(s) already driven. Runs one
    // operation from grant through response handshake; returns after the
    // negedge of the cycle following the handshake.
    task automatic serve(input int exp_id, input logic [127:0] exp_ops, input int d,
                         input bit keep, input int bp,
                         input logic [127:0] exp_data, input logic exp_err);
        int n;
        int lat;
        int g;
        dp_delay = d;
        n = 0;
        while (!(bus.req0_ready || bus.req1_ready) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("grant_seen", bus.req0_ready | bus.req1_ready, 1'b1);
        if (!(bus.req0_ready || bus.req1_ready)) return;
        chk("grant_id", bus.req1_ready, exp_id[0]);
        chk("one_ready", bus.req0_ready & bus.req1_ready, 1'b0);
        @(posedge clk); #1;
        last_m = exp_id;
        if (!keep) begin
            if (exp_id == 0) bus.req0_valid = 1'b0;
            else             bus.req1_valid = 1'b0;
        end
        @(negedge clk);
        chk("load", {bus.dp_load, bus.dp_compute}, 2'b10);
        chk("dp_ops", bus.dp_ops, exp_ops);
        chk("busy_ready", bus.req0_ready | bus.req1_ready, 1'b0);
        @(negedge clk);
        chk("compute", {bus.dp_load, bus.dp_compute}, 2'b01);
        chk("dp_ops_hold", bus.dp_ops, exp_ops);
        lat = 2;
        while (!bus.rsp_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, (d == 0) ? 3 + TIMEOUT : 3 + d);
        if (!bus.rsp_valid) return;
        chk("rsp_id", bus.rsp_id, exp_id[0]);
        chk("rsp_err", bus.rsp_err, exp_err);
        chk("rsp_data", bus.rsp_data, exp_data);
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("bp_ctl", {bus.rsp_valid, bus.rsp_id, bus.rsp_err}, {1'b1, exp_id[0], exp_err});
            chk("bp_data", bus.rsp_data, exp_data);
            chk("bp_ready", bus.req0_ready | bus.req1_ready, 1'b0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("hs_ready", bus.req0_ready | bus.req1_ready, 1'b0);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("rsp_drop", bus.rsp_valid, 1'b0);
        g = mgrant(bus.req0_valid, bus.req1_valid, last_m);
        chk("idle_ready", {bus.req0_ready, bus.req1_ready}, {g == 0, g == 1});
    endtask

    initial begin
        logic [127:0] ops_a;
        logic [127:0] ops_b;
        int           id;
        int           quiet;

        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_ops = 128'd0;
        bus.req1_valid = 1'b0; bus.req1_ops = 128'd0;
        bus.rsp_ready  = 1'b0;
        @(negedge clk); @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        last_m = 1;

        // Single op on requester 0, positive values
        bus.req0_ops = pack8(1, 2, 3, 4, 5, 6, 7, 8);
        bus.req0_valid = 1'b1;
        @(negedge clk);
        serve(0, bus.req0_ops, 3, 1'b0, 0, {32'd19, 32'd22, 32'd43, 32'd50}, 1'b0);

        // Mixed signs on requester 1
        @(posedge clk); #1;
        bus.req1_ops = pack8(-1, 2, -3, 4, 5, -6, 7, -8);
        bus.req1_valid = 1'b1;
        @(negedge clk);
        serve(1, bus.req1_ops, 3, 1'b0, 0, {32'd9, 32'hFFFFFFF6, 32'd13, 32'hFFFFFFF2}, 1'b0);

        // Backpressure on requester 0's response while requester 1 waits
        @(posedge clk); #1;
        ops_a = pack8(7, -7, 100, 3, -2, 9, 11, -4);
        ops_b = pack8(-300, 12, 5, 5, 6, -1, 0, 2);
        bus.req0_ops = ops_a; bus.req0_valid = 1'b1;
        bus.req1_ops = ops_b; bus.req1_valid = 1'b1;
        @(negedge clk);
        serve(0, ops_a, 2, 1'b0, 5, matmul(ops_a), 1'b0);
        serve(1, ops_b, 1, 1'b0, 0, matmul(ops_b), 1'b0);

        // Datapath never answers: timeout error
        @(posedge clk); #1;
        ops_a = pack8(1, 1, 1, 1, 1, 1, 1, 1);
        bus.req0_ops = ops_a; bus.req0_valid = 1'b1;
        @(negedge clk);
        serve(0, ops_a, 0, 1'b0, 0, 128'd0, 1'b1);

        // Contention from reset: grants alternate 0,1,0,1
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        last_m = 1;
        ops_a = pack8(2, 0, 0, 2, 3, 4, 5, 6);
        ops_b = pack8(-5, 1, 1, -5, 2, 2, 2, 2);
        bus.req0_ops = ops_a; bus.req0_valid = 1'b1;
        bus.req1_ops = ops_b; bus.req1_valid = 1'b1;
        @(negedge clk);
        serve(0, ops_a, 1, 1'b1, 0, matmul(ops_a), 1'b0);
        serve(1, ops_b, 2, 1'b1, 0, matmul(ops_b), 1'b0);
        serve(0, ops_a, 3, 1'b1, 0, matmul(ops_a), 1'b0);
        serve(1, ops_b, 1, 1'b0, 0, matmul(ops_b), 1'b0);

        // Requester 0 is still valid and granted now; let it reach WAIT, then reset
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        dp_delay = 0;
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        last_m = 1;
        @(negedge clk);
        chk_reset_outputs("mid_wait_reset");
        quiet = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) quiet++;
        end
        chk("no_stale_rsp", quiet, 0);
        @(posedge clk); #1;
        ops_a = pack8(-32768, 32767, -1, 1, 32767, -32768, 2, -2);
        bus.req0_ops = ops_a; bus.req0_valid = 1'b1;
        @(negedge clk);
        serve(0, ops_a, 2, 1'b0, 0, matmul(ops_a), 1'b0);

        // Randomized operations
        for (int it = 0; it < 10; it++) begin
            int d;
            int bp;
            @(posedge clk); #1;
            id    = $urandom_range(0, 1);
            d     = $urandom_range(1, 6);
            bp    = $urandom_range(0, 2);
            ops_a = {$urandom, $urandom, $urandom, $urandom};
            if (id == 0) begin bus.req0_ops = ops_a; bus.req0_valid = 1'b1; end
            else         begin bus.req1_ops = ops_a; bus.req1_valid = 1'b1; end
            @(negedge clk);
            serve(id, ops_a, d, 1'b0, bp, matmul(ops_a), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
